// File: rtl/loom_dpi_bridge.sv
// loom_dpi_bridge: DUT-side valid/ready bridge to one DPI register-file call/return slot
module loom_dpi_bridge #(
    parameter int unsigned MAX_ARGS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dut_req_valid_i,
    output logic                     dut_req_ready_o,
    input  logic [MAX_ARGS*32-1:0]   dut_req_args_i,
    output logic                     dut_rsp_valid_o,
    input  logic                     dut_rsp_ready_i,
    output logic [63:0]              dut_rsp_result_o,
    output logic [MAX_ARGS*32-1:0]   dut_rsp_args_o,
    output logic                     dpi_call_valid_o,
    input  logic                     dpi_call_ready_i,
    output logic [MAX_ARGS*32-1:0]   dpi_call_args_o,
    input  logic                     dpi_ret_valid_i,
    output logic                     dpi_ret_ready_o,
    input  logic [64+MAX_ARGS*32-1:0] dpi_ret_data_i,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [31:0]              call_count_o
);
    localparam int unsigned AW = MAX_ARGS * 32;

    typedef enum logic [1:0] {IDLE, CALL, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   args_q;
    logic [63:0]     result_q;
    logic [31:0]     count_q;
    logic [31:0]     wait_q;
    logic            timeout_q;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // next state and Moore handshake outputs; ready is held low while in reset
    always_comb begin
        state_n          = state;
        dut_req_ready_o  = 1'b0;
        dpi_call_valid_o = 1'b0;
        dpi_ret_ready_o  = 1'b0;
        dut_rsp_valid_o  = 1'b0;
        case (state)
            IDLE: begin
                dut_req_ready_o = rst_ni;
                if (dut_req_valid_i) state_n = CALL;
            end
            CALL: begin
                dpi_call_valid_o = 1'b1;
                if (dpi_call_ready_i) state_n = WAIT;
            end
            WAIT: begin
                dpi_ret_ready_o = 1'b1;
                if (dpi_ret_valid_i) state_n = RESP;
            end
            RESP: begin
                dut_rsp_valid_o = 1'b1;
                if (dut_rsp_ready_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // args/result capture, completed-call counter, wait counter and sticky timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            args_q    <= '0;
            result_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && dut_req_valid_i) args_q <= dut_req_args_i;
            if (state == WAIT && dpi_ret_valid_i) begin
                result_q <= dpi_ret_data_i[63:0];
                args_q   <= dpi_ret_data_i[64 +: AW];
                if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
            end
            if (state == CALL && dpi_call_ready_i) wait_q <= '0;
            else if (state == WAIT && wait_q != 32'hFFFF_FFFF) wait_q <= wait_q + 32'd1;
            if (TIMEOUT_CYCLES != 0 && state == WAIT && !dpi_ret_valid_i &&
                wait_q == 32'(TIMEOUT_CYCLES - 1))
                timeout_q <= 1'b1;
        end
    end

    assign busy_o           = (state != IDLE);
    assign dpi_call_args_o  = args_q;
    assign dut_rsp_args_o   = args_q;
    assign dut_rsp_result_o = result_q;
    assign call_count_o     = count_q;
    assign timeout_o        = timeout_q;
endmodule

// File: tb/tb_loom_dpi_bridge.sv
// tb_loom_dpi_bridge: directed scenario bench for loom_dpi_bridge (timeout 16 and timeout 0 instances in lockstep)
module tb_loom_dpi_bridge;
    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_CALL = 5'b11000;
    localparam logic [4:0] S_WAIT = 5'b10100;
    localparam logic [4:0] S_RESP = 5'b10010;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [255:0] req_args = '0;
    logic         call_ready = 1'b0;
    logic         ret_valid = 1'b0;
    logic [319:0] ret_data = '0;
    logic         rsp_ready = 1'b0;

    logic         req_ready, rsp_valid, call_valid, ret_ready, busy, timeout;
    logic [63:0]  rsp_result;
    logic [255:0] rsp_args, call_args;
    logic [31:0]  count;

    logic         z_req_ready, z_rsp_valid, z_call_valid, z_ret_ready, z_busy, z_timeout;
    logic [63:0]  z_rsp_result;
    logic [255:0] z_rsp_args, z_call_args;
    logic [31:0]  z_count;

    logic [4:0]   st;
    assign st = {busy, call_valid, ret_ready, rsp_valid, req_ready};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    loom_dpi_bridge #(.MAX_ARGS(8), .TIMEOUT_CYCLES(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dut_req_valid_i(req_valid), .dut_req_ready_o(req_ready), .dut_req_args_i(req_args),
        .dut_rsp_valid_o(rsp_valid), .dut_rsp_ready_i(rsp_ready),
        .dut_rsp_result_o(rsp_result), .dut_rsp_args_o(rsp_args),
        .dpi_call_valid_o(call_valid), .dpi_call_ready_i(call_ready), .dpi_call_args_o(call_args),
        .dpi_ret_valid_i(ret_valid), .dpi_ret_ready_o(ret_ready), .dpi_ret_data_i(ret_data),
        .busy_o(busy), .timeout_o(timeout), .call_count_o(count)
    );

    loom_dpi_bridge #(.MAX_ARGS(8), .TIMEOUT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .dut_req_valid_i(req_valid), .dut_req_ready_o(z_req_ready), .dut_req_args_i(req_args),
        .dut_rsp_valid_o(z_rsp_valid), .dut_rsp_ready_i(rsp_ready),
        .dut_rsp_result_o(z_rsp_result), .dut_rsp_args_o(z_rsp_args),
        .dpi_call_valid_o(z_call_valid), .dpi_call_ready_i(call_ready), .dpi_call_args_o(z_call_args),
        .dpi_ret_valid_i(ret_valid), .dpi_ret_ready_o(z_ret_ready), .dpi_ret_data_i(ret_data),
        .busy_o(z_busy), .timeout_o(z_timeout), .call_count_o(z_count)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({st, timeout} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", {st, timeout}, 6'b0); end
        total++; if ({call_args, rsp_args, rsp_result, count} !== '0) begin bad++; $display("FAIL reset_regs result=%h count=%h args=%h", rsp_result, count, call_args); end
        rst_n = 1'b1;
        tick();
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL reset_release_idle got=%b exp=%b", st, S_IDLE); end
    endtask

    task automatic test_basic;
        logic [255:0] a;
        logic         all_busy;
        a = {192'h0, 32'hABCD, 32'h1234};
        req_args = a; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        total++; if (st !== S_CALL) begin bad++; $display("FAIL basic_call_state got=%b exp=%b", st, S_CALL); end
        total++; if (call_args !== a) begin bad++; $display("FAIL basic_call_args got=%h exp=%h", call_args, a); end
        tick();
        call_ready = 1'b0;
        total++; if (st !== S_WAIT) begin bad++; $display("FAIL basic_wait_state got=%b exp=%b", st, S_WAIT); end
        all_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (busy !== 1'b1 || st !== S_WAIT) all_busy = 1'b0;
        end
        total++; if (all_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_wait got=%b exp=1", all_busy); end
        ret_valid = 1'b1; ret_data = {256'h0, 64'hCAFE_0000_0000_BEEF};
        tick();
        ret_valid = 1'b0;
        total++; if (st !== S_RESP) begin bad++; $display("FAIL basic_resp_state got=%b exp=%b", st, S_RESP); end
        total++; if (rsp_result !== 64'hCAFE_0000_0000_BEEF) begin bad++; $display("FAIL basic_result got=%h exp=%h", rsp_result, 64'hCAFE_0000_0000_BEEF); end
        total++; if (count !== 32'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL basic_idle got=%b exp=%b", st, S_IDLE); end
    endtask

    task automatic test_backpressure;
        logic [255:0] a, b;
        logic         stable;
        a = {128'h0, 32'h3333_3333, 32'h0, 32'h0, 32'h1111_1111};
        b = {32'h8888_0008, 224'h0};
        req_args = a; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (st !== S_CALL || call_args !== a) stable = 1'b0;
            tick();
        end
        total++; if (stable !== 1'b1 || st !== S_CALL) begin bad++; $display("FAIL bp_call_hold stable=%b state=%b exp_state=%b", stable, st, S_CALL); end
        call_ready = 1'b1;
        tick();
        call_ready = 1'b0;
        total++; if (st !== S_WAIT || count !== 32'd1) begin bad++; $display("FAIL bp_wait state=%b count=%0d exp_state=%b exp_count=1", st, count, S_WAIT); end
        ret_valid = 1'b1; ret_data = {b, 64'h0123_4567_89AB_CDEF};
        tick();
        ret_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (st !== S_RESP || rsp_result !== 64'h0123_4567_89AB_CDEF || rsp_args !== b || count !== 32'd2) stable = 1'b0;
            tick();
        end
        total++; if (stable !== 1'b1 || st !== S_RESP) begin bad++; $display("FAIL bp_rsp_hold stable=%b state=%b exp_state=%b", stable, st, S_RESP); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE || count !== 32'd2) begin bad++; $display("FAIL bp_single_count state=%b count=%0d exp_count=2", st, count); end
    endtask

    task automatic test_output_args;
        logic [255:0] r;
        r = {32'h7000_0007, 128'h0, 32'h5555_AAAA, 32'h0, 32'hDEAD_BEEF};
        req_args = {224'h0, 32'h0000_0042}; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        call_ready = 1'b0;
        ret_valid = 1'b1; ret_data = {r, 64'h2};
        tick();
        ret_valid = 1'b0;
        total++; if (rsp_args[95:64] !== 32'h5555_AAAA) begin bad++; $display("FAIL outargs_word2 got=%h exp=%h", rsp_args[95:64], 32'h5555_AAAA); end
        total++; if (rsp_args !== r) begin bad++; $display("FAIL outargs_all got=%h exp=%h", rsp_args, r); end
        total++; if (rsp_result !== 64'h2 || count !== 32'd3) begin bad++; $display("FAIL outargs_result result=%h count=%0d exp_result=2 exp_count=3", rsp_result, count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_busy_request;
        logic [255:0] c, d, e;
        c = {224'h0, 32'hC0C0_C0C0};
        d = {224'h0, 32'hD0D0_D0D0};
        e = {224'h0, 32'hE0E0_E0E0};
        req_args = c; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        call_ready = 1'b0;
        req_args = d; req_valid = 1'b1;
        total++; if (st !== S_WAIT) begin bad++; $display("FAIL busy_wait_ready got=%b exp=%b", st, S_WAIT); end
        tick(); tick();
        total++; if (st !== S_WAIT || call_args !== c) begin bad++; $display("FAIL busy_inflight_args state=%b got=%h exp=%h", st, call_args, c); end
        ret_valid = 1'b1; ret_data = {e, 64'h3};
        tick();
        ret_valid = 1'b0;
        total++; if (st !== S_RESP || rsp_args !== e) begin bad++; $display("FAIL busy_resp state=%b got=%h exp=%h", st, rsp_args, e); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE || count !== 32'd4) begin bad++; $display("FAIL busy_back_idle state=%b count=%0d exp_count=4", st, count); end
        call_ready = 1'b1;
        tick();
        total++; if (st !== S_CALL || call_args !== d) begin bad++; $display("FAIL busy_second_accept state=%b got=%h exp=%h", st, call_args, d); end
        req_valid = 1'b0;
        tick();
        call_ready = 1'b0;
        ret_valid = 1'b1; ret_data = {c, 64'h4};
        tick();
        ret_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE || count !== 32'd5) begin bad++; $display("FAIL busy_second_done state=%b count=%0d exp_count=5", st, count); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_seq [8];
        exp_seq = '{S_CALL, S_WAIT, S_RESP, S_IDLE, S_CALL, S_WAIT, S_RESP, S_IDLE};
        req_args = {224'h0, 32'h0000_0B2B};
        ret_data = {224'h0, 32'h0000_0F0F, 64'h5};
        req_valid = 1'b1; call_ready = 1'b1; ret_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) req_valid = 1'b0;
            total++; if (st !== exp_seq[i]) begin bad++; $display("FAIL b2b_step%0d got=%b exp=%b", i, st, exp_seq[i]); end
        end
        call_ready = 1'b0; ret_valid = 1'b0; rsp_ready = 1'b0;
        total++; if (count !== 32'd7 || rsp_result !== 64'h5) begin bad++; $display("FAIL b2b_count count=%0d result=%h exp_count=7 exp_result=5", count, rsp_result); end
    endtask

    task automatic test_timeout;
        logic z_rise;
        req_args = {224'h0, 32'h0000_7117}; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        call_ready = 1'b0;
        total++; if (st !== S_WAIT || timeout !== 1'b0) begin bad++; $display("FAIL to_start state=%b timeout=%b exp_timeout=0", st, timeout); end
        z_rise = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (z_timeout !== 1'b0) z_rise = 1'b1;
            if (i == 15) begin
                total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", timeout); end
            end
            if (i == 16) begin
                total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_rise got=%b exp=1", timeout); end
            end
        end
        total++; if (z_rise !== 1'b0) begin bad++; $display("FAIL to_disabled got=%b exp=0", z_rise); end
        total++; if (st !== S_WAIT || timeout !== 1'b1) begin bad++; $display("FAIL to_hold state=%b timeout=%b exp_timeout=1", st, timeout); end
        ret_valid = 1'b1; ret_data = {256'h0, 64'h6};
        tick();
        ret_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE || timeout !== 1'b1 || count !== 32'd8) begin bad++; $display("FAIL to_sticky state=%b timeout=%b count=%0d exp_count=8", st, timeout, count); end
        total++; if (z_count !== 32'd8 || z_timeout !== 1'b0) begin bad++; $display("FAIL to_zero_inst count=%0d timeout=%b exp_count=8", z_count, z_timeout); end
    endtask

    task automatic test_reset_mid;
        logic [255:0] h;
        h = {224'h0, 32'h0000_4444};
        req_args = {224'h0, 32'h0000_3333}; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        call_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++; if ({st, timeout} !== 6'b0) begin bad++; $display("FAIL rmid_ctrl got=%b exp=%b", {st, timeout}, 6'b0); end
        total++; if ({count, z_count, rsp_result, call_args} !== '0) begin bad++; $display("FAIL rmid_regs count=%0d result=%h args=%h", count, rsp_result, call_args); end
        @(negedge clk);
        rst_n = 1'b1;
        req_args = h; req_valid = 1'b1; call_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        total++; if (st !== S_CALL || call_args !== h) begin bad++; $display("FAIL rmid_call state=%b got=%h exp=%h", st, call_args, h); end
        tick();
        call_ready = 1'b0;
        ret_valid = 1'b1; ret_data = {256'h0, 64'h9999};
        tick();
        ret_valid = 1'b0;
        total++; if (st !== S_RESP || rsp_result !== 64'h9999 || count !== 32'd1) begin bad++; $display("FAIL rmid_resp state=%b result=%h count=%0d exp_result=9999 exp_count=1", st, rsp_result, count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL rmid_idle got=%b exp=%b", st, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_output_args();
        test_busy_request();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
